mem_bus_master: RTL and testbench

- Initiator side of the shared 8-bit memory bus: address_bus, wr_en, rd_en, rom_ram and the bidirectional data_bus.
- Accepts single-beat read/write requests from the core over a valid/ready handshake and sequences the bus strobes.
- Drives data_bus only during RAM writes; captures read data from the RAM or ROM responder.
- Sits between the CPU datapath and the RAM/ROM responders. It is the only bus driver apart from the responders' read data.

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/mem_bus_master.sv | 99 +++++++++
 tb/tb_mem_bus_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the 8-bit memory bus (master and RAM/ROM responders).
package mem_bus_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        TURN   = 2'd3
    } state_t;

    localparam logic RAM_SEL    = 1'b1;
    localparam logic ROM_SEL    = 1'b0;
    localparam int   DATA_W     = 8;
    localparam int   BUS_ADDR_W = 15;
endpackage

// File: rtl/mem_bus_master.sv
// Memory bus initiator: one valid/ready request in, SETUP/ACCESS/TURN strobe sequence out.
// Latency: rsp_valid WAIT_STATES+3 cycles after accept; req_ready low while a transfer is in flight.
module mem_bus_master #(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 16,
    parameter int BUS_ADDR_W  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [7:0]            req_wdata,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_err,
    output logic [BUS_ADDR_W-1:0] address_bus,
    output logic                  rom_ram,
    output logic                  rd_en,
    output logic                  wr_en,
    inout  wire  [7:0]            data_bus
);
    import mem_bus_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drv_en;
    logic              accept;

    assign accept = (state == IDLE) && req_valid && req_ready;

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        drv_en    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SETUP;
            end
            SETUP: begin
                drv_en    = we_q && (rom_ram == RAM_SEL);
                state_nxt = (we_q && (rom_ram == ROM_SEL)) ? TURN : ACCESS;
            end
            ACCESS: begin
                rd_en  = !we_q;
                wr_en  = we_q;
                drv_en = we_q;
                if (wait_cnt == 4'd0) state_nxt = TURN;
            end
            TURN: begin
                rsp_valid = 1'b1;
                rsp_err   = we_q && (rom_ram == ROM_SEL);
                // write data stays on the bus one extra cycle for responder hold time
                drv_en    = we_q && (rom_ram == RAM_SEL);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            address_bus <= '0;
            rom_ram     <= ROM_SEL;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wait_cnt    <= 4'd0;
            rsp_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == IDLE);
            if (accept) begin
                address_bus <= req_addr[BUS_ADDR_W-1:0];
                rom_ram     <= req_addr[ADDR_W-1];
                we_q        <= req_we;
                wdata_q     <= req_wdata;
            end
            if (state == SETUP) begin
                wait_cnt <= 4'(WAIT_STATES);
            end else if ((state == ACCESS) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if ((state == ACCESS) && (wait_cnt == 4'd0) && !we_q) begin
                rsp_rdata <= data_bus;
            end
        end
    end

    assign data_bus = drv_en ? wdata_q : 8'hzz;
endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench: two masters (0 and 3 wait states) sharing request inputs, each with its own bus and responder.
module tb_mem_bus_master;
    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;

    logic        ready0, ready3;
    logic        rsp_valid0, rsp_valid3;
    logic [7:0]  rsp_rdata0, rsp_rdata3;
    logic        rsp_err0, rsp_err3;
    logic [14:0] address_bus0, address_bus3;
    logic        rom_ram0, rom_ram3;
    logic        rd_en0, rd_en3;
    logic        wr_en0, wr_en3;
    wire  [7:0]  data_bus0, data_bus3;

    logic        probe0, probe3;
    logic [7:0]  mem0 [0:32767];
    logic [7:0]  mem3 [0:32767];
    logic [7:0]  rd_val0, rd_val3;

    int total;
    int passed;

    mem_bus_master #(.WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .address_bus(address_bus0), .rom_ram(rom_ram0), .rd_en(rd_en0),
        .wr_en(wr_en0), .data_bus(data_bus0)
    );

    mem_bus_master #(.WAIT_STATES(3)) u3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .address_bus(address_bus3), .rom_ram(rom_ram3), .rd_en(rd_en3),
        .wr_en(wr_en3), .data_bus(data_bus3)
    );

    // Responders: RAM array, ROM returns addr[7:0]^8'h3C. Probe drives 8'h5A to show the master has released the bus.
    assign rd_val0   = rom_ram0 ? mem0[address_bus0] : (address_bus0[7:0] ^ 8'h3C);
    assign rd_val3   = rom_ram3 ? mem3[address_bus3] : (address_bus3[7:0] ^ 8'h3C);
    assign data_bus0 = rd_en0 ? rd_val0 : (probe0 ? 8'h5A : 8'hzz);
    assign data_bus3 = rd_en3 ? rd_val3 : (probe3 ? 8'h5A : 8'hzz);

    always @(posedge clk) begin
        if (wr_en0 && rom_ram0) mem0[address_bus0] <= data_bus0;
        if (wr_en3 && rom_ram3) mem3[address_bus3] <= data_bus3;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(ready0 && ready3) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'd0, ready0 && ready3}, 32'd1);
    endtask

    task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    initial begin
        int n;
        total     = 0;
        passed    = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        probe0    = 1'b0;
        probe3    = 1'b0;
        mem3[15'h7FFF] = 8'h3C;

        // reset held for 3 cycles
        repeat (3) @(negedge clk);
        probe0 = 1'b1;
        #1;
        check("rst_ready",  {31'd0, ready0}, 32'd0);
        check("rst_strobe", {30'd0, rd_en0, wr_en0}, 32'd0);
        check("rst_addr",   {16'd0, rom_ram0, address_bus0}, 32'd0);
        check("rst_rsp",    {23'd0, rsp_valid0, rsp_rdata0}, 32'd0);
        check("rst_bus_z",  {24'd0, data_bus0}, 32'h5A);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {30'd0, ready0, ready3}, 32'd3);
        check("idle_rsp_err", {30'd0, rsp_valid0, rsp_err0}, 32'd0);
        probe0 = 1'b0;

        // RAM write, 0 wait states
        issue(1'b1, 16'h8012, 8'hA5);
        @(negedge clk);
        req_valid = 1'b0;
        check("wr_setup_ready", {31'd0, ready0}, 32'd0);
        check("wr_setup_addr",  {16'd0, rom_ram0, address_bus0}, {16'd0, 1'b1, 15'h0012});
        check("wr_setup_strb",  {30'd0, rd_en0, wr_en0}, 32'd0);
        check("wr_setup_bus",   {24'd0, data_bus0}, 32'hA5);
        @(negedge clk);
        check("wr_access_strb", {30'd0, rd_en0, wr_en0}, 32'd1);
        check("wr_access_bus",  {24'd0, data_bus0}, 32'hA5);
        check("wr_access_rsp",  {31'd0, rsp_valid0}, 32'd0);
        @(negedge clk);
        check("wr_turn_rsp",    {30'd0, rsp_valid0, rsp_err0}, 32'd2);
        check("wr_turn_strb",   {30'd0, rd_en0, wr_en0}, 32'd0);
        check("wr_turn_hold",   {24'd0, data_bus0}, 32'hA5);
        check("wr_mem",         {24'd0, mem0[15'h0012]}, 32'hA5);
        @(negedge clk);
        check("wr_idle",        {30'd0, ready0, rsp_valid0}, 32'd2);

        // RAM read back
        issue(1'b0, 16'h8012, 8'h00);
        @(negedge clk);
        req_valid = 1'b0;
        check("rd_setup_strb",  {30'd0, rd_en0, wr_en0}, 32'd0);
        @(negedge clk);
        check("rd_access_strb", {30'd0, rd_en0, wr_en0}, 32'd2);
        check("rd_access_bus",  {24'd0, data_bus0}, 32'hA5);
        @(negedge clk);
        check("rd_turn",        {22'd0, rsp_valid0, rsp_err0, rsp_rdata0}, {22'd0, 2'b10, 8'hA5});
        @(negedge clk);

        // ROM write rejected
        probe0 = 1'b1;
        issue(1'b1, 16'h0040, 8'h77);
        @(negedge clk);
        req_valid = 1'b0;
        check("romwr_setup",    {29'd0, rom_ram0, rd_en0, wr_en0}, 32'd0);
        check("romwr_bus_z",    {24'd0, data_bus0}, 32'h5A);
        @(negedge clk);
        check("romwr_turn",     {28'd0, rsp_valid0, rsp_err0, rd_en0, wr_en0}, 32'b1100);
        check("romwr_turn_bus", {24'd0, data_bus0}, 32'h5A);
        @(negedge clk);
        check("romwr_idle",     {30'd0, ready0, rsp_valid0}, 32'd2);
        probe0 = 1'b0;

        // ROM read
        issue(1'b0, 16'h0040, 8'h00);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("romrd_access",   {29'd0, rom_ram0, rd_en0, wr_en0}, 32'b010);
        @(negedge clk);
        check("romrd_turn",     {22'd0, rsp_valid0, rsp_err0, rsp_rdata0}, {22'd0, 2'b10, 8'h7C});

        // 3 wait states: read 16'hFFFF
        wait_idle();
        issue(1'b0, 16'hFFFF, 8'h00);
        @(negedge clk);
        req_valid = 1'b0;
        check("ws_setup",       {14'd0, rom_ram3, address_bus3, rd_en3, rsp_valid3}, {14'd0, 1'b1, 15'h7FFF, 2'b00});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ws_access",  {14'd0, rom_ram3, address_bus3, rd_en3, rsp_valid3}, {14'd0, 1'b1, 15'h7FFF, 2'b10});
        end
        @(negedge clk);
        check("ws_turn",        {22'd0, rd_en3, rsp_valid3, rsp_rdata3}, {22'd0, 2'b01, 8'h3C});

        // back-to-back writes with req_valid held
        wait_idle();
        issue(1'b1, 16'h8020, 8'h11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_busy_ready", {31'd0, ready0}, 32'd0);
            check("b2b_no_overlap", {31'd0, rd_en0 && wr_en0}, 32'd0);
        end
        check("b2b_first_turn", {31'd0, rsp_valid0}, 32'd1);
        req_addr  = 16'h8021;
        req_wdata = 8'h22;
        @(negedge clk);
        check("b2b_ready_after_turn", {31'd0, ready0}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_second_setup", {15'd0, ready0, address_bus0, 1'b0}, {15'd0, 1'b0, 15'h0021, 1'b0});
        @(negedge clk);
        check("b2b_second_access", {22'd0, wr_en0, rd_en0, data_bus0}, {22'd0, 2'b10, 8'h22});
        @(negedge clk);
        check("b2b_second_turn", {31'd0, rsp_valid0}, 32'd1);
        check("b2b_mem", {16'd0, mem0[15'h0020], mem0[15'h0021]}, 32'h1122);

        // reset during ACCESS of a 3-wait-state write
        wait_idle();
        issue(1'b1, 16'h8030, 8'h99);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rstmid_wr_on", {31'd0, wr_en3}, 32'd1);
        reset  = 1'b1;
        probe3 = 1'b1;
        @(negedge clk);
        check("rstmid_strobes", {29'd0, wr_en3, rd_en3, rsp_valid3}, 32'd0);
        check("rstmid_bus_z", {24'd0, data_bus3}, 32'h5A);
        reset  = 1'b0;
        probe3 = 1'b0;
        @(negedge clk);
        check("rstmid_ready", {30'd0, ready3, rsp_valid3}, 32'd2);
        wait_idle();
        issue(1'b0, 16'h0005, 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
        end while (!rsp_valid3 && n < 20);
        check("rstmid_fresh_latency", n, 32'd6);
        check("rstmid_fresh_data", {23'd0, rsp_err3, rsp_rdata3}, {23'd0, 1'b0, 8'h39});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
